// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity-mode codes and baud divider helper.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } rx_state_e;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  // Clocks per bit; also used by the transmitter so both ends divide identically.
  function automatic int unsigned baud_cnt_max(input int unsigned clk_freq,
                                               input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx pin plus a falling-edge detector.
module uart_rx_sync (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic rx,
  output logic rx_s,
  output logic rx_fall
);

  logic meta_q, sync_q, dly_q;

  // Idle line is high, so reset to 1 to avoid a spurious edge after reset.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      dly_q  <= 1'b1;
    end else begin
      meta_q <= rx;
      sync_q <= meta_q;
      dly_q  <= sync_q;
    end
  end

  assign rx_s    = sync_q;
  assign rx_fall = dly_q & ~sync_q;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with parity/framing error reporting and false-start rejection.
// Define UART_RX_MAJORITY_EN to resolve each bit by 2-of-3 majority around the bit centre.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 50_000_000,
  parameter int unsigned BAUD_RATE   = 9600,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY_MODE = 0,
  parameter int unsigned STOP_BITS   = 1
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] po_data,
  output logic                 po_data_flag,
  output logic                 po_parity_err,
  output logic                 po_frame_err,
  output logic                 rx_busy
);

  localparam int unsigned     BaudMax  = baud_cnt_max(CLK_FREQ, BAUD_RATE);
  localparam int unsigned     CntW     = (BaudMax > 2) ? $clog2(BaudMax) : 1;
  localparam logic [CntW-1:0] CntLast  = CntW'(BaudMax - 1);
  localparam logic [3:0]      LastData = 4'(DATA_BITS - 1);
  localparam logic [3:0]      LastStop = 4'(STOP_BITS - 1);
  localparam logic            OddPar   = (PARITY_MODE == PAR_ODD);

  if (DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
      PARITY_MODE > PAR_EVEN || BaudMax < 4) begin : gen_bad_params
    $error("uart_rx_param: illegal DATA_BITS, STOP_BITS, PARITY_MODE or baud ratio");
  end

  logic                 rx_s, rx_fall;
  rx_state_e            state_q, state_d;
  logic [CntW-1:0]      baud_cnt_q, baud_cnt_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_err_q, frm_err_q;
  logic [DATA_BITS-1:0] po_data_q;
  logic                 po_data_flag_q, po_parity_err_q, po_frame_err_q;
  logic                 cnt_wrap, samp_en, samp_bit;
  logic                 start_det, shift_en, par_chk, stop_chk, frame_done;

  uart_rx_sync u_sync (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .rx      (rx),
    .rx_s    (rx_s),
    .rx_fall (rx_fall)
  );

  assign cnt_wrap = (baud_cnt_q == CntLast);

`ifdef UART_RX_MAJORITY_EN
  localparam logic [CntW-1:0] CntEarly = CntW'(BaudMax / 2 - 1);
  localparam logic [CntW-1:0] CntMid   = CntW'(BaudMax / 2);
  localparam logic [CntW-1:0] CntLate  = CntW'(BaudMax / 2 + 1);

  logic [1:0] early_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      early_q <= 2'b11;
    end else begin
      if (baud_cnt_q == CntEarly) early_q[0] <= rx_s;
      if (baud_cnt_q == CntMid)   early_q[1] <= rx_s;
    end
  end

  assign samp_en  = (state_q != StIdle) && (baud_cnt_q == CntLate);
  assign samp_bit = (early_q[0] & early_q[1]) | (early_q[0] & rx_s) | (early_q[1] & rx_s);
`else
  localparam logic [CntW-1:0] CntMid = CntW'(BaudMax / 2);

  assign samp_en  = (state_q != StIdle) && (baud_cnt_q == CntMid);
  assign samp_bit = rx_s;
`endif

  // State register
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (rx_fall) state_d = StStart;
      end
      StStart: begin
        if (samp_en && samp_bit) begin
          state_d = StIdle;
        end else if (cnt_wrap) begin
          state_d = StData;
        end
      end
      StData: begin
        if (cnt_wrap && (bit_cnt_q == LastData)) begin
          state_d = (PARITY_MODE != PAR_NONE) ? StParity : StStop;
        end
      end
      StParity: begin
        if (cnt_wrap) state_d = StStop;
      end
      StStop: begin
        // Leave at the last stop sample so a start edge in its second half is caught.
        if (samp_en && (bit_cnt_q == LastStop)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output / control decode
  always_comb begin
    rx_busy    = (state_q != StIdle);
    start_det  = (state_q == StIdle) && rx_fall;
    shift_en   = (state_q == StData) && samp_en;
    par_chk    = (state_q == StParity) && samp_en;
    stop_chk   = (state_q == StStop) && samp_en;
    frame_done = stop_chk && (bit_cnt_q == LastStop);
  end

  always_comb begin
    baud_cnt_d = baud_cnt_q + CntW'(1);
    if (state_q == StIdle || state_d == StIdle || cnt_wrap) baud_cnt_d = '0;
  end

  // bit_cnt restarts at every state change, so it indexes data bits and then stop bits.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    if (state_q != state_d) begin
      bit_cnt_d = '0;
    end else if (cnt_wrap) begin
      bit_cnt_d = bit_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      baud_cnt_q      <= '0;
      bit_cnt_q       <= '0;
      shift_q         <= '0;
      par_err_q       <= 1'b0;
      frm_err_q       <= 1'b0;
      po_data_q       <= '0;
      po_data_flag_q  <= 1'b0;
      po_parity_err_q <= 1'b0;
      po_frame_err_q  <= 1'b0;
    end else begin
      baud_cnt_q     <= baud_cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      po_data_flag_q <= frame_done;
      if (start_det) begin
        par_err_q <= 1'b0;
        frm_err_q <= 1'b0;
      end
      // LSB arrives first; after DATA_BITS shifts it sits in bit 0.
      if (shift_en) shift_q <= {samp_bit, shift_q[DATA_BITS-1:1]};
      if (par_chk) par_err_q <= samp_bit ^ (^shift_q) ^ OddPar;
      if (stop_chk && !samp_bit) frm_err_q <= 1'b1;
      if (frame_done) begin
        po_data_q       <= shift_q;
        po_parity_err_q <= par_err_q;
        po_frame_err_q  <= frm_err_q | ~samp_bit;
      end
    end
  end

  assign po_data       = po_data_q;
  assign po_data_flag  = po_data_flag_q;
  assign po_parity_err = po_parity_err_q;
  assign po_frame_err  = po_frame_err_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: three configurations driven with directed and random frames.
module tb_uart_rx_param;

  localparam int BIT = 16;

  typedef struct {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic       clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       rx0 = 1'b1, rx1 = 1'b1, rx2 = 1'b1;
  logic [7:0] data0, data1;
  logic [6:0] data2;
  logic       flag0, flag1, flag2, perr0, perr1, perr2, ferr0, ferr1, ferr2;
  logic       busy0, busy1, busy2;

  exp_t q0[$], q1[$], q2[$];
  exp_t e0, e1, e2;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  uart_rx_param #(
    .CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)
  ) u_dut0 (
    .sys_clk(clk), .sys_rst(sys_rst), .rx(rx0), .po_data(data0), .po_data_flag(flag0),
    .po_parity_err(perr0), .po_frame_err(ferr0), .rx_busy(busy0)
  );

  uart_rx_param #(
    .CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)
  ) u_dut1 (
    .sys_clk(clk), .sys_rst(sys_rst), .rx(rx1), .po_data(data1), .po_data_flag(flag1),
    .po_parity_err(perr1), .po_frame_err(ferr1), .rx_busy(busy1)
  );

  uart_rx_param #(
    .CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(2)
  ) u_dut2 (
    .sys_clk(clk), .sys_rst(sys_rst), .rx(rx2), .po_data(data2), .po_data_flag(flag2),
    .po_parity_err(perr2), .po_frame_err(ferr2), .rx_busy(busy2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitors: pop the oldest expected word whenever a DUT raises its flag.
  always @(negedge clk) begin
    if (flag0) begin
      check("dut0 flag expected", 32'(q0.size() > 0), 32'd1);
      if (q0.size() > 0) begin
        e0 = q0.pop_front();
        check("dut0 data", 32'(data0), 32'(e0.data));
        check("dut0 parity_err", 32'(perr0), 32'(e0.perr));
        check("dut0 frame_err", 32'(ferr0), 32'(e0.ferr));
      end
    end
  end

  always @(negedge clk) begin
    if (flag1) begin
      check("dut1 flag expected", 32'(q1.size() > 0), 32'd1);
      if (q1.size() > 0) begin
        e1 = q1.pop_front();
        check("dut1 data", 32'(data1), 32'(e1.data));
        check("dut1 parity_err", 32'(perr1), 32'(e1.perr));
        check("dut1 frame_err", 32'(ferr1), 32'(e1.ferr));
      end
    end
  end

  always @(negedge clk) begin
    if (flag2) begin
      check("dut2 flag expected", 32'(q2.size() > 0), 32'd1);
      if (q2.size() > 0) begin
        e2 = q2.pop_front();
        check("dut2 data", 32'(data2), 32'(e2.data));
        check("dut2 parity_err", 32'(perr2), 32'(e2.perr));
        check("dut2 frame_err", 32'(ferr2), 32'(e2.ferr));
      end
    end
  end

  task automatic set_line(input int idx, input logic v);
    case (idx)
      0:       rx0 = v;
      1:       rx1 = v;
      default: rx2 = v;
    endcase
  endtask

  task automatic drive_bit(input int idx, input logic v);
    set_line(idx, v);
    repeat (BIT) @(posedge clk);
  endtask

  // Reference: frame layout and expected results derived from the configuration alone.
  task automatic send_frame(input int idx, input logic [8:0] data, input bit bad_par,
                            input logic [1:0] stops, input int gap);
    int         nb, pm, ns;
    logic [8:0] d, sh;
    logic [1:0] st;
    logic       par;
    exp_t       e;
    case (idx)
      0:       begin nb = 8; pm = 0; ns = 1; end
      1:       begin nb = 8; pm = 2; ns = 1; end
      default: begin nb = 7; pm = 1; ns = 2; end
    endcase
    d = data & ((9'd1 << nb) - 9'd1);
    par = (^d) ^ (pm == 1);
    e.data = d;
    e.perr = (pm != 0) && bad_par;
    e.ferr = !stops[0] || (ns == 2 && !stops[1]);
    case (idx)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
    drive_bit(idx, 1'b0);
    sh = d;
    for (int i = 0; i < nb; i++) begin
      drive_bit(idx, sh[0]);
      sh = sh >> 1;
    end
    if (pm != 0) drive_bit(idx, par ^ bad_par);
    st = stops;
    for (int s = 0; s < ns; s++) begin
      drive_bit(idx, st[0]);
      st = st >> 1;
    end
    set_line(idx, 1'b1);
    repeat (gap) @(posedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " dut0 data"}, 32'(data0), 32'd0);
    check({tag, " dut0 flag"}, 32'(flag0), 32'd0);
    check({tag, " dut0 parity_err"}, 32'(perr0), 32'd0);
    check({tag, " dut0 frame_err"}, 32'(ferr0), 32'd0);
    check({tag, " dut0 busy"}, 32'(busy0), 32'd0);
  endtask

  logic [8:0] rdata;
  bit         rbad;
  logic [1:0] rstops;
  int         rgap;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    check("reset dut1 data", 32'(data1), 32'd0);
    check("reset dut1 busy", 32'(busy1), 32'd0);
    check("reset dut2 data", 32'(data2), 32'd0);
    check("reset dut2 flag", 32'(flag2), 32'd0);
    @(posedge clk);
    sys_rst = 1'b0;
    repeat (4) @(posedge clk);

    // Back-to-back 0x00..0x07, no parity, one stop bit
    for (int i = 0; i < 8; i++) send_frame(0, 9'(i), 1'b0, 2'b11, 0);
    repeat (BIT) @(posedge clk);

    // Even parity: wrong then correct parity bit
    send_frame(1, 9'h0A5, 1'b1, 2'b11, BIT);
    send_frame(1, 9'h0A5, 1'b0, 2'b11, BIT);

    // Stop bit low, then a clean frame
    send_frame(0, 9'h03C, 1'b0, 2'b10, BIT);
    send_frame(0, 9'h03D, 1'b0, 2'b11, BIT);

    // 7 data bits, odd parity, two stop bits
    send_frame(2, 9'h041, 1'b0, 2'b11, BIT);

    // False start: short low pulse must be rejected at the start sample point
    @(posedge clk);
    rx0 = 1'b0;
    repeat (4) @(posedge clk);
    rx0 = 1'b1;
    @(negedge clk);
    check("false start busy rises", 32'(busy0), 32'd1);
    repeat (BIT) @(posedge clk);
    @(negedge clk);
    check("false start busy falls", 32'(busy0), 32'd0);

    // Reset in the middle of data bit 3 of 0x5A
    @(posedge clk);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b0);
    rx0 = 1'b1;
    repeat (BIT / 2) @(posedge clk);
    sys_rst = 1'b1;
    rx0 = 1'b1;
    @(posedge clk);
    sys_rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid-frame reset");
    repeat (2 * BIT) @(posedge clk);
    send_frame(0, 9'h05A, 1'b0, 2'b11, BIT);

    // Random frames on all three configurations
    for (int n = 0; n < 20; n++) begin
      for (int d = 0; d < 3; d++) begin
        rdata  = 9'($urandom);
        rbad   = ($urandom_range(0, 3) == 0);
        rstops = 2'b11;
        if ($urandom_range(0, 4) == 0) rstops[0] = 1'b0;
        if ($urandom_range(0, 4) == 0) rstops[1] = 1'b0;
        rgap = $urandom_range(0, BIT);
        if (rstops != 2'b11) rgap = BIT;
        send_frame(d, rdata, rbad, rstops, rgap);
      end
    end

    repeat (4 * BIT) @(posedge clk);
    check("dut0 pending words", 32'(q0.size()), 32'd0);
    check("dut1 pending words", 32'(q1.size()), 32'd0);
    check("dut2 pending words", 32'(q2.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
